// File: rtl/interval_meter.sv
// interval_meter: measures clk cycles between a sampled start and a sampled stop.
// The result is held in HOLD until a valid/ready handshake. The live counter
// saturates at all-ones, and a saturated measurement is flagged with ovf.
// A start that arrives while a result is still pending sets the sticky 'missed' flag.
// Optional feature: define INTERVAL_METER_THRESHOLD_EN to enable the live
// threshold comparator. Without that macro, 'threshold' is tied low and 'thr' is unused.
module interval_meter #(
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] thr,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             running,
    output logic             threshold,
    output logic             missed
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CountMax = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             missed_q, missed_d;
    logic             countSat;

    // During RUN, count_q holds the number of fully elapsed RUN cycles.
    // The interval therefore comes out as count_q + 1 when stop is sampled.
    assign countSat = (count_q == CountMax);

    // Next-state logic: the measurement FSM, the saturating counter, and result capture.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        missed_d = missed_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    count_d = '0;
                end
            end
            RUN: begin
                if (!countSat) begin
                    count_d = count_q + 1'b1;
                end
                if (stop) begin
                    state_d  = HOLD;
                    result_d = countSat ? CountMax : (count_q + 1'b1);
                    ovf_d    = countSat;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        state_d = RUN;
                        count_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start) begin
                    missed_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset. Reset discards any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            missed_q <= missed_d;
        end
    end

    assign result    = result_q;
    assign ovf       = ovf_q;
    assign missed    = missed_q;
    assign running   = (state_q == RUN);
    assign out_valid = (state_q == HOLD);

`ifdef INTERVAL_METER_THRESHOLD_EN
    assign threshold = (state_q == RUN) && (count_q >= thr);
`else
    logic unusedThr;
    assign unusedThr = ^thr;
    assign threshold = 1'b0;
`endif

endmodule

// File: tb/tb_interval_meter.sv
// tb_interval_meter: scoreboard bench for interval_meter, built with WIDTH=8.
// Expected results are queued when stop is driven and are compared when out_valid is seen.
// Threshold expectations follow INTERVAL_METER_THRESHOLD_EN in the same way as the DUT.
module tb_interval_meter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, stop, out_ready;
    logic [W-1:0] thr;
    logic [W-1:0] result;
    logic         ovf, out_valid, running, threshold, missed;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int unsigned res;
        bit          ovf;
    } exp_t;
    exp_t expQ[$];

    interval_meter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .thr(thr),
        .result(result), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready),
        .running(running), .threshold(threshold), .missed(missed)
    );

    // Free-running clock. Stimulus is driven and outputs are sampled on the falling edge.
    always #5 clk = ~clk;

    // Safety net: stop the run if the bench stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected threshold in RUN cycle k. The live count is k-1, saturated at 255.
    function automatic bit expThreshold(input int k);
        int live;
        live = (k - 1 > 255) ? 255 : k - 1;
`ifdef INTERVAL_METER_THRESHOLD_EN
        return (live >= int'(thr));
`else
        return 1'b0;
`endif
    endfunction

    // Runs RUN cycles 1..n and samples stop at edge N+n. Call this just after the start edge.
    task automatic run_body(input int n);
        exp_t e;
        for (int k = 1; k <= n; k++) begin
            checks++;
            if (running !== 1'b1) begin
                errors++;
                $display("[TB] FAIL run_running k=%0d got=%b exp=1", k, running);
            end
            checks++;
            if (threshold !== expThreshold(k)) begin
                errors++;
                $display("[TB] FAIL run_threshold k=%0d got=%b exp=%b", k, threshold, expThreshold(k));
            end
            if (k == n) stop = 1'b1;
            tick();
            if (k == n) stop = 1'b0;
        end
        e.res = (n > 255) ? 255 : n;
        e.ovf = (n > 255);
        expQ.push_back(e);
    endtask

    task automatic measure(input int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_body(n);
    endtask

    // Waits a bounded number of cycles for out_valid, then checks against the scoreboard.
    task automatic collect();
        exp_t e;
        int   waitCnt;
        waitCnt = 0;
        while (out_valid !== 1'b1 && waitCnt < 10) begin
            tick();
            waitCnt++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL out_valid_timeout got=%b exp=1", out_valid);
        end else if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty got=result %0d exp=queued entry", result);
        end else begin
            e = expQ.pop_front();
            if (result !== W'(e.res)) begin
                errors++;
                $display("[TB] FAIL result got=%0d exp=%0d", result, e.res);
            end
            checks++;
            if (ovf !== e.ovf) begin
                errors++;
                $display("[TB] FAIL ovf got=%b exp=%b", ovf, e.ovf);
            end
            checks++;
            if (running !== 1'b0 || threshold !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_flags got=running %b threshold %b exp=0 0", running, threshold);
            end
        end
    endtask

    // After a handshake, the DUT must be back in IDLE.
    task automatic expect_idle(input string tag);
        checks++;
        if (out_valid !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s got=out_valid %b running %b exp=0 0", tag, out_valid, running);
        end
    endtask

    // Checks that every output is at its reset value.
    task automatic expect_cleared(input string tag);
        checks++;
        if ({result, ovf, out_valid, running, threshold, missed} !== '0) begin
            errors++;
            $display("[TB] FAIL %s got=result %0d ovf %b valid %b run %b thr %b missed %b exp=all 0",
                     tag, result, ovf, out_valid, running, threshold, missed);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; stop = 1'b0; out_ready = 1'b0; thr = 8'd0;
        tick(); tick();
        expect_cleared("reset_state");
        rst = 1'b0;
        tick();
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_start_after_reset got=%b exp=1", running);
        end
        start = 1'b0;
        out_ready = 1'b1;
        run_body(4);
        collect();
        tick();
        expect_idle("reset_followup_idle");
    endtask

    task automatic test_basic();
        thr = 8'd20; out_ready = 1'b1;
        tick(); tick();
        measure(34);
        collect();
        checks++;
        if (missed !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_missed got=%b exp=0", missed);
        end
        tick();
        expect_idle("basic_valid_one_cycle");
    endtask

    task automatic test_saturation();
        thr = 8'd200; out_ready = 1'b1;
        measure(255);
        collect();
        tick();
        measure(300);
        collect();
        tick();
        expect_idle("saturation_idle");
    endtask

    task automatic test_threshold();
        out_ready = 1'b1;
        thr = 8'd12;
        measure(20);
        collect();
        tick();
        thr = 8'd0;
        measure(3);
        collect();
        tick();
        expect_idle("threshold_idle");
    endtask

    task automatic test_ignored_inputs();
        exp_t e;
        out_ready = 1'b1; thr = 8'd2;
        stop = 1'b1; tick(); stop = 1'b0;
        expect_idle("stop_in_idle");
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        checks++;
        if (running !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_stop_idle got=running %b valid %b exp=1 0", running, out_valid);
        end
        for (int k = 1; k <= 6; k++) begin
            start = (k == 3 || k == 6);
            stop  = (k == 6);
            tick();
        end
        start = 1'b0; stop = 1'b0;
        e.res = 6; e.ovf = 1'b0;
        expQ.push_back(e);
        collect();
        tick();
        expect_idle("start_with_stop_in_run");
    endtask

    task automatic test_hold_missed();
        out_ready = 1'b0; thr = 8'd0;
        measure(7);
        collect();
        for (int i = 1; i <= 20; i++) begin
            start = (i == 5);
            stop  = (i == 9);
            tick();
            start = 1'b0; stop = 1'b0;
            checks++;
            if (result !== 8'd7 || out_valid !== 1'b1 || running !== 1'b0 || missed !== (i >= 5)) begin
                errors++;
                $display("[TB] FAIL hold_stable i=%0d got=result %0d valid %b run %b missed %b exp=7 1 0 %b",
                         i, result, out_valid, running, missed, (i >= 5));
            end
        end
        out_ready = 1'b1;
        tick();
        expect_idle("hold_release_idle");
        checks++;
        if (missed !== 1'b1) begin
            errors++;
            $display("[TB] FAIL missed_sticky got=%b exp=1", missed);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; thr = 8'd3;
        measure(9);
        collect();
        out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (running !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL back_to_back got=running %b valid %b exp=1 0", running, out_valid);
        end
        run_body(5);
        collect();
        tick();
        expect_idle("back_to_back_idle");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; thr = 8'd1;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        expect_cleared("reset_mid_run");
        measure(4);
        collect();
        rst = 1'b1; tick(); rst = 1'b0;
        expect_cleared("reset_mid_hold");
        out_ready = 1'b1;
        measure(6);
        collect();
        tick();
        expect_idle("reset_recovery_idle");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_threshold();
        test_ignored_inputs();
        test_hold_missed();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_leftover got=%0d exp=0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interval_meter.md
INTERVAL_METER -- requirements
Module: interval_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 48: counter and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin interval measurement (level-sampled each edge).
REQ-005 SHALL have port stop  input  1  end interval measurement.
REQ-006 SHALL have port thr  input  WIDTH  threshold compare value.
REQ-007 SHALL have port result  output  WIDTH  measured interval in clk cycles.
REQ-008 SHALL have port ovf  output  1  result saturated; qualified by out_valid.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port running  output  1  measurement in progress.
REQ-012 SHALL have port threshold  output  1  live count has reached thr.
REQ-013 SHALL have port missed  output  1  sticky: start dropped while result pending.

Function
REQ-014 SHALL implement states IDLE, RUN, HOLD; running = (state==RUN); out_valid = (state==HOLD).
REQ-015 IDLE: start sampled high at edge N -> RUN from N+1; live counter restarts; stop in IDLE ignored.
REQ-016 IDLE, start and stop high on same edge: start accepted, stop ignored.
REQ-017 RUN: stop sampled at edge M -> result = M-N (minimum 1), state HOLD, out_valid high from cycle M+1.
REQ-018 RUN: start ignored (no restart); start and stop on same edge treated as stop only.
REQ-019 Live counter SHALL saturate at all-ones, never wrap; if saturated when stop sampled, result = all-ones and ovf = 1, else ovf = 0.
REQ-020 HOLD: result and ovf SHALL stay stable until out_valid & out_ready at an edge; then IDLE next cycle.
REQ-021 HOLD: handshake and start on same edge -> result consumed, start accepted, RUN next cycle (back-to-back, no IDLE cycle).
REQ-022 HOLD: start without handshake -> start dropped, missed set to 1 next cycle; missed cleared only by rst.
REQ-023 HOLD: stop ignored.
REQ-024 out_valid SHALL not depend combinationally on out_ready.

Reset
REQ-025 rst high at an edge -> IDLE; result = 0, ovf = 0, out_valid = 0, running = 0, threshold = 0, missed = 0, counter = 0.
REQ-026 rst SHALL override all inputs, including mid-RUN and mid-HOLD; pending result discarded, no handshake required.
REQ-027 First start accepted at the first edge where rst is low.

Configuration
REQ-028 Macro INTERVAL_METER_THRESHOLD_EN SHALL gate threshold logic.
REQ-029 Defined: threshold = 1 in each RUN cycle where live count >= thr (thr = 0 -> high for all of RUN); 0 outside RUN.
REQ-030 Undefined: threshold tied 0; thr ignored; comparator absent; all other behaviour identical.

Verification
REQ-031 start edge 10, stop edge 44, out_ready=1 -> out_valid high cycle 45 only, result = 34, ovf = 0.
REQ-032 WIDTH=8, start, no stop for 300 cycles, then stop -> result = 255, ovf = 1, no wrap.
REQ-033 out_ready=0 in HOLD for 20 cycles, start pulsed -> result stable, missed = 1; out_ready=1 -> IDLE, missed stays 1.
REQ-034 HOLD with out_ready=1 and start same edge -> next cycle running = 1, out_valid = 0; second stop 5 edges later -> result = 5.
REQ-035 rst asserted mid-RUN and separately mid-HOLD -> all outputs 0 next cycle; new start/stop 6 apart -> result = 6.
REQ-036 Macro defined, thr = 12, interval 20 -> threshold low first 12 RUN cycles, high cycles 13..20; macro undefined -> threshold always 0.
